// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one shared 1-bit full-adder slice processes the
// operands LSB-first over WIDTH clocks and the result is reassembled at the end.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_bit;

  assign s_bit = a_reg[0] ^ b_reg[0] ^ carry;
  assign c_bit = (a_reg[0] & b_reg[0]) | ((a_reg[0] ^ b_reg[0]) & carry);

  // Partial sums build up in acc so that sum keeps the previous result until
  // the final slice edge, where the last bit and acc are written together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: a_reg/b_reg/acc are pure datapath, always loaded before use, so
      // they are left out of reset; only control and visible results are cleared.
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          acc   <= {s_bit, acc[WIDTH-1:1]};
          carry <= c_bit;
          if (cnt == LAST) begin
            sum   <= {s_bit, acc[WIDTH-1:1]};
            cout  <= c_bit;
            ovf   <= carry ^ c_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl at WIDTH=8 and WIDTH=16: directed
// vector table, multi-cycle corner sequences and a scoreboarded random sweep.
module tb_serial_addsub_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  exp_t q8[$];
  exp_t q16[$];
  int   passed = 0;
  int   total  = 0;

  // Reference: wide add of a + (b or ~b) + sub; overflow from operand/result signs.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic sub);
    logic [63:0] mask, aa, bb, full;
    exp_t e;
    mask   = (64'd1 << w) - 64'd1;
    aa     = {32'b0, a} & mask;
    bb     = (sub ? ~{32'b0, b} : {32'b0, b}) & mask;
    full   = aa + bb + {63'b0, sub};
    e.sum  = full[31:0] & mask[31:0];
    e.cout = full[w];
    e.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(int w, logic st, logic [31:0] a, logic [31:0] b, logic sub);
    if (w == 8) begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; sub8 = sub;
    end else begin
      start16 = st; a16 = a[15:0]; b16 = b[15:0]; sub16 = sub;
    end
  endtask

  task automatic outs(int w, output logic bz, output logic dn, output logic [31:0] s,
                      output logic c, output logic o);
    if (w == 8) begin
      bz = busy8; dn = done8; s = 32'(sum8); c = cout8; o = ovf8;
    end else begin
      bz = busy16; dn = done16; s = 32'(sum16); c = cout16; o = ovf16;
    end
  endtask

  // Drive a request while the DUT is idle and push its expected result.
  task automatic start_op(int w, logic [31:0] a, logic [31:0] b, logic sub, bit hold);
    @(negedge clk);
    drive(w, 1'b1, a, b, sub);
    if (w == 8) q8.push_back(model(8, a, b, sub));
    else        q16.push_back(model(16, a, b, sub));
    @(posedge clk);
    #1;
    if (!hold) drive(w, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Poll for done (bounded), then pop the scoreboard and compare.
  task automatic wait_done(int w, bit scramble, output int lat, output int busy_cnt,
                           output int done_cyc);
    logic bz, dn, c, o;
    logic [31:0] s;
    exp_t e;
    bit got;
    got = 0; lat = 0; busy_cnt = 0; done_cyc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      outs(w, bz, dn, s, c, o);
      if (bz && dn) check("busy_done_overlap", 32'(bz && dn), 32'd0);
      if (bz) busy_cnt++;
      if (dn) got = 1;
      else if (scramble) drive(w, 1'b1, $urandom, $urandom, 1'($urandom));
    end
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    done_cyc = int'(cyc);
    drive(w, 1'b0, 32'h0, 32'h0, 1'b0);
    if (w == 8) e = q8.pop_front();
    else        e = q16.pop_front();
    check("sb_sum", s, e.sum);
    check("sb_cout", 32'(c), 32'(e.cout));
    check("sb_ovf", 32'(o), 32'(e.ovf));
  endtask

  vec_t vecs[5];

  initial begin
    int lat, bc, dc, prev, ndone;
    logic bz, dn, c, o;
    logic [31:0] s;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, sub: 1'b0, sum: 8'h96, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h10, b: 8'h20, sub: 1'b1, sum: 8'hF0, cout: 1'b0, ovf: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h01, sub: 1'b1, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 8'h7F, b: 8'h7F, sub: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};

    rst = 1'b1;
    drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    foreach (vecs[i]) begin end
    for (int w = 8; w <= 16; w += 8) begin
      outs(w, bz, dn, s, c, o);
      check("rst_busy", 32'(bz), 32'd0);
      check("rst_done", 32'(dn), 32'd0);
      check("rst_sum", s, 32'd0);
      check("rst_cout", 32'(c), 32'd0);
      check("rst_ovf", 32'(o), 32'd0);
    end
    rst = 1'b0;

    // Directed vectors: latency, busy length, table result and one-cycle done.
    for (int i = 0; i < 5; i++) begin
      start_op(8, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].sub, 1'b0);
      wait_done(8, 1'b0, lat, bc, dc);
      check("latency", 32'(lat), 32'd9);
      check("busy_cycles", 32'(bc), 32'd8);
      check("vec_sum", 32'(sum8), 32'(vecs[i].sum));
      check("vec_cout", 32'(cout8), 32'(vecs[i].cout));
      check("vec_ovf", 32'(ovf8), 32'(vecs[i].ovf));
      @(negedge clk);
      check("done_pulse_width", 32'(done8), 32'd0);
    end

    // start held high with operands changing during RUN/DONE.
    start_op(8, 32'h11, 32'h22, 1'b0, 1'b1);
    wait_done(8, 1'b1, lat, bc, dc);
    check("hold_sum", 32'(sum8), 32'h33);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("hold_single_done", 32'(ndone), 32'd0);
    check("hold_sum_kept", 32'(sum8), 32'h33);
    start_op(8, 32'h40, 32'h05, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("sum_held_in_run", 32'(sum8), 32'h33);
    wait_done(8, 1'b0, lat, bc, dc);
    check("second_sum", 32'(sum8), 32'h3B);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    start_op(8, 32'h5A, 32'h3C, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(q8.pop_back());
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_sum", 32'(sum8), 32'd0);
    check("midrst_cout", 32'(cout8), 32'd0);
    check("midrst_ovf", 32'(ovf8), 32'd0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    start_op(8, 32'h01, 32'h01, 1'b0, 1'b0);
    wait_done(8, 1'b0, lat, bc, dc);
    check("post_rst_sum", 32'(sum8), 32'h02);

    // Random back-to-back sweep at both widths; done period must be WIDTH+2.
    for (int w = 8; w <= 16; w += 8) begin
      @(negedge clk);
      prev = 0;
      for (int i = 0; i < 1000; i++) begin
        start_op(w, $urandom, $urandom, 1'($urandom), 1'b0);
        wait_done(w, 1'b0, lat, bc, dc);
        if (i > 0) check("done_period", 32'(dc - prev), 32'(w + 2));
        prev = dc;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
